// File: rtl/neopixel_multi.sv
// ---------------------------------------------------------------------------
// neopixel_multi : multi-channel WS2812/SK6812 driver with Avalon-MM pixel RAM
// Optional macro NEOPIXEL_BRIGHTNESS_EN adds the BRIGHT scaling register.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module neopixel_multi #(
  parameter int CLOCK_SPEED_HZ     = 50_000_000,
  parameter int NUMBER_OF_CHANNELS = 2,
  parameter int PIXELS_PER_CHANNEL = 35,
  parameter int RGBW               = 1,
  parameter int T0H_NS             = 300,
  parameter int T1H_NS             = 600,
  parameter int TBIT_NS            = 1200,
  parameter int TLATCH_NS          = 80000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [15:0]                   address,
  input  logic                          write,
  input  logic [31:0]                   writedata,
  input  logic                          read,
  output logic [31:0]                   readdata,
  output logic                          waitrequest,
  output logic [NUMBER_OF_CHANNELS-1:0] one_wire,
  output logic                          frame_done
);

  function automatic int ns_to_cyc(input longint ns);
    longint c;
    c = (longint'(CLOCK_SPEED_HZ) / 64'sd1000) * ns / 64'sd1000000;
    return (c < 1) ? 1 : int'(c);
  endfunction

  localparam int T0H_C    = ns_to_cyc(longint'(T0H_NS));
  localparam int T1H_C    = ns_to_cyc(longint'(T1H_NS));
  localparam int TBIT_C   = ns_to_cyc(longint'(TBIT_NS));
  localparam int TLATCH_C = ns_to_cyc(longint'(TLATCH_NS));
  localparam int TMAX_A   = (TBIT_C > TLATCH_C) ? TBIT_C : TLATCH_C;
  localparam int TMAX     = (T1H_C > TMAX_A) ? T1H_C : TMAX_A;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int BPP      = (RGBW != 0) ? 32 : 24;
  localparam int NPIX     = NUMBER_OF_CHANNELS * PIXELS_PER_CHANNEL;
  localparam int AW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW       = (PIXELS_PER_CHANNEL > 1) ? $clog2(PIXELS_PER_CHANNEL) : 1;

  localparam logic [TW-1:0] TBIT_END   = TW'(TBIT_C - 1);
  localparam logic [TW-1:0] LATCH_END  = TW'(TLATCH_C - 1);
  localparam logic [TW-1:0] T0H_T      = TW'(T0H_C);
  localparam logic [TW-1:0] T1H_T      = TW'(T1H_C);
  localparam logic [4:0]    BIT_TOP    = 5'(BPP - 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(PIXELS_PER_CHANNEL - 1);
  localparam logic [16:0]   NPIX_W     = 17'(NPIX);
  localparam logic [31:0]   PIX_MASK   = (RGBW != 0) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, LATCH = 2'd2} state_t;

  state_t                          state_q;
  logic [TW-1:0]                   tmr_q;
  logic [PW-1:0]                   pix_q;
  logic [4:0]                      bidx_q;
  logic                            busy_q;
  logic                            pending_q;
  logic                            frame_done_q;
  logic [NUMBER_OF_CHANNELS-1:0]   one_wire_q;
  logic [NUMBER_OF_CHANNELS-1:0]   bits_q;
  logic [31:0]                     mem [NPIX];

  logic [15:0]                     w_idx;
  logic                            w_is_pix;
  logic                            w_ctrl_wr;
  logic                            w_pix_we;
  logic [NUMBER_OF_CHANNELS-1:0]   w_fetch_bit;
  logic [NUMBER_OF_CHANNELS-1:0]   w_cur_bits;
  logic [NUMBER_OF_CHANNELS-1:0]   w_hi_d;
  logic                            w_unused_read;

`ifdef NEOPIXEL_BRIGHTNESS_EN
  logic [7:0] bright_q;

  function automatic logic [31:0] scale_word(input logic [31:0] w, input logic [7:0] b);
    logic [31:0] r;
    logic [16:0] p;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      p = 17'(w[8*k +: 8]) * (17'(b) + 17'd1);
      r[8*k +: 8] = 8'(p >> 8);
    end
    return r;
  endfunction
`endif

  assign w_unused_read = read;
  assign w_idx         = address - 16'd2;
  assign w_is_pix      = (address >= 16'd2) && ({1'b0, w_idx} < NPIX_W);
  assign w_ctrl_wr     = write && (address == 16'd0);
  assign w_pix_we      = write && w_is_pix && !busy_q;
  assign waitrequest   = busy_q & write & (address >= 16'd2);
  assign one_wire      = one_wire_q;
  assign frame_done    = frame_done_q;

  always_ff @(posedge clock) begin
    if (w_pix_we) mem[w_idx[AW-1:0]] <= writedata & PIX_MASK;
  end

  always_comb begin
    readdata = 32'hDEAD_BEEF;
    if (w_is_pix) readdata = mem[w_idx[AW-1:0]];
    if (address == 16'd0) readdata = {30'b0, pending_q, busy_q};
`ifdef NEOPIXEL_BRIGHTNESS_EN
    if (address == 16'd1) readdata = {24'b0, bright_q};
`endif
  end

  // Every channel reads its own pixel word in parallel; all share pix_q/bidx_q.
  for (genvar ch = 0; ch < NUMBER_OF_CHANNELS; ch++) begin : g_ch
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_word;
    assign w_raddr = AW'(ch * PIXELS_PER_CHANNEL) + AW'(pix_q);
`ifdef NEOPIXEL_BRIGHTNESS_EN
    assign w_word  = scale_word(mem[w_raddr], bright_q);
`else
    assign w_word  = mem[w_raddr];
`endif
    assign w_fetch_bit[ch] = w_word[bidx_q];
    assign w_hi_d[ch]      = tmr_q < (w_cur_bits[ch] ? T1H_T : T0H_T);
  end

  assign w_cur_bits = (tmr_q == '0) ? w_fetch_bit : bits_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      pix_q        <= '0;
      bidx_q       <= BIT_TOP;
      busy_q       <= 1'b0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      one_wire_q   <= '0;
      bits_q       <= '0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
      bright_q     <= 8'hFF;
`endif
    end else begin
      frame_done_q <= 1'b0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
      if (write && (address == 16'd1)) bright_q <= writedata[7:0];
`endif
      if (w_ctrl_wr && (state_q != IDLE)) pending_q <= writedata[0];
      case (state_q)
        IDLE: begin
          one_wire_q <= '0;
          if ((w_ctrl_wr && writedata[0]) || pending_q) begin
            state_q   <= SEND;
            tmr_q     <= '0;
            pix_q     <= '0;
            bidx_q    <= BIT_TOP;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        SEND: begin
          one_wire_q <= w_hi_d;
          if (tmr_q == '0) bits_q <= w_fetch_bit;
          if (tmr_q == TBIT_END) begin
            tmr_q <= '0;
            if (bidx_q == 5'd0) begin
              bidx_q <= BIT_TOP;
              if (pix_q == PIX_LAST) state_q <= LATCH;
              else                   pix_q   <= pix_q + PW'(1);
            end else begin
              bidx_q <= bidx_q - 5'd1;
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        LATCH: begin
          one_wire_q <= '0;
          if (tmr_q == LATCH_END) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neopixel_multi.sv
// ---------------------------------------------------------------------------
// tb_neopixel_multi : randomized scoreboard bench for neopixel_multi (RGB, 2x2)
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_neopixel_multi;

  localparam int CLK_HZ = 50_000_000;
  localparam int NCH    = 2;
  localparam int PPC    = 2;
  localparam int BPP    = 24;

  function automatic int cyc_of(input longint ns);
    longint c;
    c = (longint'(CLK_HZ) / 1000) * ns / 1_000_000;
    return (c < 1) ? 1 : int'(c);
  endfunction

  localparam int T0H    = cyc_of(300);
  localparam int T1H    = cyc_of(600);
  localparam int TBIT   = cyc_of(1200);
  localparam int TLATCH = cyc_of(80000);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [15:0]     address = '0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic            read = 1'b0;
  logic [31:0]     readdata;
  logic            waitrequest;
  logic [NCH-1:0]  one_wire;
  logic            frame_done;

  neopixel_multi #(
    .CLOCK_SPEED_HZ(CLK_HZ), .NUMBER_OF_CHANNELS(NCH), .PIXELS_PER_CHANNEL(PPC),
    .RGBW(0), .T0H_NS(300), .T1H_NS(600), .TBIT_NS(1200), .TLATCH_NS(80000)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .one_wire(one_wire), .frame_done(frame_done)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pixel contents, brightness, and expected high-time per bit.
  logic [31:0] model_mem [NCH][PPC];
  logic [7:0]  model_bright = 8'hFF;
  int          q_hi0[$];
  int          q_hi1[$];
  int          exp_frames  = 0;
  int          frames_seen = 0;
  int          last_fall   = 0;

  function automatic logic [31:0] tx_word(input logic [31:0] w);
    logic [31:0] r;
    r = w & 32'h00FF_FFFF;
`ifdef NEOPIXEL_BRIGHTNESS_EN
    r = '0;
    for (int k = 0; k < 3; k++) begin
      int by;
      by = int'((w >> (8 * k)) & 32'hFF);
      r = r | (32'((by * (int'(model_bright) + 1)) / 256) << (8 * k));
    end
`endif
    return r;
  endfunction

  task automatic push_frame();
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < PPC; p++) begin
        logic [31:0] w;
        w = tx_word(model_mem[ch][p]);
        for (int k = BPP - 1; k >= 0; k--) begin
          int hi;
          hi = w[k] ? T1H : T0H;
          if (ch == 0) q_hi0.push_back(hi);
          else         q_hi1.push_back(hi);
        end
      end
    exp_frames++;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, output int stall_cycles);
    logic stalled;
    int   n;
    n = 0;
    @(posedge clock); #1;
    address = a; writedata = d; write = 1'b1;
    do begin
      #1 stalled = waitrequest;
      @(posedge clock);
      n++;
    end while (stalled && n < 10000);
    if (stalled) check("write accept timeout", 64'd1, 64'd0);
    #1 write = 1'b0; address = '0;
    stall_cycles = n - 1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    address = a; read = 1'b1;
    #5 d = readdata;
    read = 1'b0; address = '0;
  endtask

  function automatic logic [15:0] pix_addr(input int ch, input int p);
    return 16'(2 + ch * PPC + p);
  endfunction

  task automatic write_model_pixels();
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < PPC; p++)
        wr(pix_addr(ch, p), model_mem[ch][p]);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_seen < target && n < 10000) begin
      @(posedge clock);
      n++;
    end
    check("frame_done count", 64'(frames_seen), 64'(target));
  endtask

  // Monitor: measure each high pulse and compare against the scoreboard.
  task automatic mon_ch(input int ch);
    int   hi, last_rise, e;
    logic prev;
    hi = 0; last_rise = -100000; prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hi = 0; prev = 1'b0; last_rise = -100000;
      end else begin
        if (one_wire[ch]) begin
          if (!prev) begin
            if (cyc - last_rise < 1000)
              check($sformatf("ch%0d bit period", ch), 64'(cyc - last_rise), 64'(TBIT));
            last_rise = cyc;
          end
          hi++;
        end else if (prev) begin
          if ((ch == 0 ? q_hi0.size() : q_hi1.size()) == 0) begin
            check($sformatf("ch%0d unexpected pulse", ch), 64'(hi), 64'd0);
          end else begin
            e = (ch == 0) ? q_hi0.pop_front() : q_hi1.pop_front();
            check($sformatf("ch%0d high time", ch), 64'(hi), 64'(e));
          end
          hi = 0;
          last_fall = cyc;
        end
        prev = one_wire[ch];
      end
    end
  endtask

  initial begin
    fork
      mon_ch(0);
      mon_ch(1);
    join_none
  end

  initial begin : lockstep_mon
    logic [NCH-1:0] prev, rises;
    prev = '0;
    forever begin
      @(negedge clock);
      if (reset) prev = '0;
      else begin
        rises = one_wire & ~prev;
        if (rises != '0) check("lockstep rise", 64'(rises), 64'({NCH{1'b1}}));
        prev = one_wire;
      end
    end
  end

  initial begin : frame_done_mon
    int gap;
    forever begin
      @(negedge clock);
      if (frame_done && !reset) begin
        frames_seen++;
        gap = cyc - last_fall;
        check("latch gap in range", 64'((gap >= TLATCH) && (gap <= TLATCH + TBIT + 2)), 64'd1);
        @(negedge clock);
        check("frame_done single cycle", 64'(frame_done), 64'd0);
      end
    end
  end

  initial begin : main
    logic [31:0] d;
    int          stalls;

    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < PPC; p++) model_mem[ch][p] = '0;

    repeat (4) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state and quiet lines.
    check("reset one_wire", 64'(one_wire), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset waitrequest", 64'(waitrequest), 64'd0);
    bus_read(16'd0, d);
    check("reset CTRL", 64'(d), 64'd0);
    begin
      int toggles;
      toggles = 0;
      for (int i = 0; i < 10000; i++) begin
        @(negedge clock);
        if (one_wire != '0 || frame_done) toggles++;
      end
      check("idle toggles", 64'(toggles), 64'd0);
    end

    // Address map edges.
    bus_read(16'd1, d);
`ifdef NEOPIXEL_BRIGHTNESS_EN
    check("BRIGHT reset", 64'(d), 64'h0000_00FF);
`else
    check("addr1 unmapped", 64'(d), 64'hDEAD_BEEF);
`endif
    wr(16'(2 + NCH * PPC), 32'h1234_5678);
    bus_read(16'(2 + NCH * PPC), d);
    check("first unmapped addr", 64'(d), 64'hDEAD_BEEF);
    bus_read(16'hFFFF, d);
    check("top unmapped addr", 64'(d), 64'hDEAD_BEEF);

    // Directed frame: ch0 px0 = 800001.
    model_mem[0][0] = 32'h0080_0001;
    write_model_pixels();
    bus_read(pix_addr(0, 0), d);
    check("pixel readback", 64'(d[23:0]), 64'h80_0001);
    wr(16'd0, 32'd1);
    push_frame();
    wait_frames(exp_frames);
    bus_read(16'd0, d);
    check("CTRL after frame", 64'(d), 64'd0);

    // Lockstep: ch1 px1 all ones, ch0 all zero.
    model_mem[0][0] = '0;
    model_mem[1][1] = 32'h00FF_FFFF;
    write_model_pixels();
    wr(16'd0, 32'd1);
    push_frame();
    wait_frames(exp_frames);

    // Randomized frames (upper byte garbage must not matter).
    for (int f = 0; f < 2; f++) begin
      for (int ch = 0; ch < NCH; ch++)
        for (int p = 0; p < PPC; p++) model_mem[ch][p] = $urandom;
`ifdef NEOPIXEL_BRIGHTNESS_EN
      model_bright = 8'($urandom);
      wr(16'd1, {24'($urandom), model_bright});
`endif
      write_model_pixels();
      for (int ch = 0; ch < NCH; ch++)
        for (int p = 0; p < PPC; p++) begin
          bus_read(pix_addr(ch, p), d);
          check("random readback", 64'(d[23:0]), 64'(model_mem[ch][p][23:0]));
        end
      wr(16'd0, 32'd1);
      push_frame();
      wait_frames(exp_frames);
    end

    // Pending start and stalled pixel write.
    wr(16'd0, 32'd1);
    push_frame();
    repeat (8) @(posedge clock);
    bus_read(16'd0, d);
    check("CTRL busy", 64'(d), 64'd1);
    wr(16'd0, 32'd1);
    bus_read(16'd0, d);
    check("CTRL pending", 64'(d), 64'd3);
    wr(16'd0, 32'd0);
    bus_read(16'd0, d);
    check("CTRL pending cleared", 64'(d), 64'd1);
    wr(16'd0, 32'd1);
    model_mem[0][1] = 32'h00A5_5A3C;
    bus_write(pix_addr(0, 1), model_mem[0][1], stalls);
    check("pixel write stalled", 64'(stalls > 1000), 64'd1);
    push_frame();
    bus_read(16'd0, d);
    check("pending frame restarted", 64'(d), 64'd1);
    bus_read(pix_addr(0, 1), d);
    check("stalled write landed", 64'(d[23:0]), 64'h00A5_5A3C);
    wait_frames(exp_frames);

    // Reset in the middle of SEND.
    wr(16'd0, 32'd1);
    push_frame();
    repeat (500) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    q_hi0.delete();
    q_hi1.delete();
    exp_frames--;
    model_bright = 8'hFF;
    check("abort one_wire low", 64'(one_wire), 64'd0);
    check("abort frame_done", 64'(frame_done), 64'd0);
    bus_read(16'd0, d);
    check("abort CTRL idle", 64'(d), 64'd0);
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < PPC; p++) begin
        bus_read(pix_addr(ch, p), d);
        check("pixel kept over reset", 64'(d[23:0]), 64'(model_mem[ch][p][23:0]));
      end

`ifdef NEOPIXEL_BRIGHTNESS_EN
    bus_read(16'd1, d);
    check("BRIGHT after reset", 64'(d), 64'h0000_00FF);
    model_bright = 8'h7F;
    wr(16'd1, 32'h0000_007F);
    bus_read(16'd1, d);
    check("BRIGHT readback", 64'(d), 64'h0000_007F);
    model_mem[0][0] = 32'h00FF_8002;
    wr(pix_addr(0, 0), model_mem[0][0]);
`endif
    wr(16'd0, 32'd1);
    push_frame();
    wait_frames(exp_frames);

    repeat (20) @(posedge clock);
    check("ch0 scoreboard drained", 64'(q_hi0.size()), 64'd0);
    check("ch1 scoreboard drained", 64'(q_hi1.size()), 64'd0);
    check("total frames", 64'(frames_seen), 64'(exp_frames));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
